// File: rtl/vcve2_dmem_arbiter_n_if.sv
// Bus bundle for the N-port data-memory arbiter.
// Holds both sides of the arbiter: the per-port requester bus (flattened vectors,
// port k in slice k) and the single OBI-style memory bus.
//   slave  : arbiter view (requests in, grants/responses out, drives memory side)
//   master : environment view (requesters plus memory, the opposite directions)
interface vcve2_dmem_arbiter_n_if #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeW = DataWidth / 8;

    // Requester side
    logic [NumPorts-1:0]           port_req_i;
    logic [NumPorts-1:0]           port_gnt_o;
    logic [NumPorts-1:0]           port_rvalid_o;
    logic [NumPorts-1:0]           port_err_o;
    logic [NumPorts-1:0]           port_lock_i;
    logic [NumPorts-1:0]           port_we_i;
    logic [NumPorts*BeW-1:0]       port_be_i;
    logic [NumPorts*AddrWidth-1:0] port_addr_i;
    logic [NumPorts*DataWidth-1:0] port_wdata_i;
    logic [DataWidth-1:0]          port_rdata_o;

    // Memory side
    logic                 data_req_o;
    logic                 data_gnt_i;
    logic                 data_rvalid_i;
    logic                 data_we_o;
    logic [BeW-1:0]       data_be_o;
    logic [AddrWidth-1:0] data_addr_o;
    logic [DataWidth-1:0] data_wdata_o;
    logic [DataWidth-1:0] data_rdata_i;
    logic                 data_err_i;

    modport slave (
        input  port_req_i, port_lock_i, port_we_i, port_be_i, port_addr_i, port_wdata_i,
        output port_gnt_o, port_rvalid_o, port_err_o, port_rdata_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport master (
        output port_req_i, port_lock_i, port_we_i, port_be_i, port_addr_i, port_wdata_i,
        input  port_gnt_o, port_rvalid_o, port_err_o, port_rdata_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/vcve2_dmem_arbiter_n.sv
// N-port data-memory arbiter.
// Selects one of NumPorts requesters (fixed priority or round-robin, with per-port
// lock) onto a single memory port and routes in-order responses back through an
// ID FIFO of depth MaxOutstanding.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   io_bus       requester and memory buses (slave modport)
//   busy_o       transactions outstanding
//   unexp_rsp_o  response arrived with no transaction outstanding (combinational pulse)
module vcve2_dmem_arbiter_n #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter bit          RoundRobin     = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    vcve2_dmem_arbiter_n_if.slave         io_bus,
    output logic                          busy_o,
    output logic                          unexp_rsp_o
);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]  r_rr_ptr;
    logic [CntW-1:0] r_count;
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [IdW-1:0]  r_fifo [MaxOutstanding];
    logic            r_lock_valid;
    logic [IdW-1:0]  r_lock_owner;

    logic                w_full;
    logic                w_empty;
    logic                w_lock_active;
    logic [NumPorts-1:0] w_lock_mask;
    logic [NumPorts-1:0] w_elig;
    logic                w_found;
    logic [IdW-1:0]      w_winner;
    logic [IdW-1:0]      w_idx;
    logic                w_push;
    logic                w_pop;
    logic [IdW-1:0]      w_head;

    assign w_full  = (r_count == CntW'(MaxOutstanding));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Lock only holds while the owner keeps its lock line high; dropping it frees
    // every port in the same cycle.
    assign w_lock_active = r_lock_valid && io_bus.port_lock_i[r_lock_owner];
    assign w_lock_mask   = w_lock_active ? (NumPorts'(1) << r_lock_owner) : '1;

    // A full FIFO blocks everyone, even if a pop happens this cycle.
    assign w_elig = (rst_i || w_full) ? '0 : (io_bus.port_req_i & w_lock_mask);

    always_comb begin
        int unsigned idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = i + (RoundRobin ? 32'(r_rr_ptr) : 32'd0);
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            w_idx = IdW'(idx);
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_push = w_found && io_bus.data_gnt_i;
    assign w_pop  = !rst_i && io_bus.data_rvalid_i && !w_empty;

    // Memory-side mux; with no winner w_winner is 0 so port 0's fields pass through.
    assign io_bus.data_req_o   = w_found;
    assign io_bus.data_we_o    = io_bus.port_we_i[w_winner];
    assign io_bus.data_be_o    = io_bus.port_be_i[w_winner*BeW +: BeW];
    assign io_bus.data_addr_o  = io_bus.port_addr_i[w_winner*AddrWidth +: AddrWidth];
    assign io_bus.data_wdata_o = io_bus.port_wdata_i[w_winner*DataWidth +: DataWidth];

    assign io_bus.port_gnt_o    = w_push ? (NumPorts'(1) << w_winner) : '0;
    assign io_bus.port_rvalid_o = w_pop ? (NumPorts'(1) << w_head) : '0;
    assign io_bus.port_err_o    = (w_pop && io_bus.data_err_i) ? (NumPorts'(1) << w_head) : '0;
    assign io_bus.port_rdata_o  = io_bus.data_rdata_i;

    assign busy_o      = !w_empty;
    assign unexp_rsp_o = !rst_i && io_bus.data_rvalid_i && w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_lock_valid <= 1'b0;
            r_lock_owner <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (RoundRobin && w_push) begin
                r_rr_ptr <= (w_winner == IdW'(NumPorts - 1)) ? '0 : w_winner + 1'b1;
            end
            if (w_push && io_bus.port_lock_i[w_winner]) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_winner;
            end else if (!w_lock_active) begin
                r_lock_valid <= 1'b0;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_winner;
        end
    end
endmodule

// File: tb/tb_vcve2_dmem_arbiter_n.sv
// Directed bench for vcve2_dmem_arbiter_n: a fixed-priority instance and a
// round-robin instance (3 ports, 2 outstanding each) driven from one timeline.
module tb_vcve2_dmem_arbiter_n;
    logic clk_i;
    logic rst_i;
    logic busy_fp, unexp_fp, busy_rr, unexp_rr;
    int   n_tests;
    int   n_fail;

    vcve2_dmem_arbiter_n_if #(.NumPorts(3), .AddrWidth(32), .DataWidth(32)) if_fp ();
    vcve2_dmem_arbiter_n_if #(.NumPorts(3), .AddrWidth(32), .DataWidth(32)) if_rr ();

    vcve2_dmem_arbiter_n #(
        .NumPorts(3), .MaxOutstanding(2), .AddrWidth(32), .DataWidth(32), .RoundRobin(1'b0)
    ) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i), .io_bus(if_fp), .busy_o(busy_fp), .unexp_rsp_o(unexp_fp)
    );

    vcve2_dmem_arbiter_n #(
        .NumPorts(3), .MaxOutstanding(2), .AddrWidth(32), .DataWidth(32), .RoundRobin(1'b1)
    ) dut_rr (
        .clk_i(clk_i), .rst_i(rst_i), .io_bus(if_rr), .busy_o(busy_rr), .unexp_rsp_o(unexp_rr)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_i   = 1'b1;
        // Assert everything during reset: outputs must stay quiet anyway.
        if_fp.port_req_i    = 3'b111;
        if_fp.port_lock_i   = 3'b000;
        if_fp.port_we_i     = 3'b000;
        if_fp.port_be_i     = '0;
        if_fp.port_addr_i   = {32'h300, 32'h200, 32'h100};
        if_fp.port_wdata_i  = '0;
        if_fp.data_gnt_i    = 1'b1;
        if_fp.data_rvalid_i = 1'b1;
        if_fp.data_rdata_i  = '0;
        if_fp.data_err_i    = 1'b0;
        if_rr.port_req_i    = 3'b000;
        if_rr.port_lock_i   = 3'b000;
        if_rr.port_we_i     = 3'b000;
        if_rr.port_be_i     = '0;
        if_rr.port_addr_i   = {32'hC00, 32'hB00, 32'hA00};
        if_rr.port_wdata_i  = '0;
        if_rr.data_gnt_i    = 1'b0;
        if_rr.data_rvalid_i = 1'b0;
        if_rr.data_rdata_i  = '0;
        if_rr.data_err_i    = 1'b0;

        tick();
        check_eq("rst_req", if_fp.data_req_o, 0);
        check_eq("rst_gnt", if_fp.port_gnt_o, 0);
        check_eq("rst_rvalid", if_fp.port_rvalid_o, 0);
        check_eq("rst_unexp", unexp_fp, 0);
        check_eq("rst_busy", busy_fp, 0);
        rst_i = 1'b0;
        if_fp.port_req_i    = 3'b000;
        if_fp.data_gnt_i    = 1'b0;
        if_fp.data_rvalid_i = 1'b0;

        // Fixed priority: ports 0 and 2 request
        tick();
        if_fp.port_req_i = 3'b101;
        if_fp.data_gnt_i = 1'b1;
        #1;
        check_eq("fp_gnt_p0", if_fp.port_gnt_o, 3'b001);
        check_eq("fp_addr_p0", if_fp.data_addr_o, 32'h100);
        check_eq("fp_req", if_fp.data_req_o, 1);
        tick();
        if_fp.port_req_i = 3'b100;
        #1;
        check_eq("fp_gnt_p2", if_fp.port_gnt_o, 3'b100);
        check_eq("fp_addr_p2", if_fp.data_addr_o, 32'h300);
        tick();
        if_fp.port_req_i    = 3'b000;
        if_fp.data_gnt_i    = 1'b0;
        if_fp.data_rvalid_i = 1'b1;
        if_fp.data_rdata_i  = 32'h11;
        #1;
        check_eq("fp_rsp0", if_fp.port_rvalid_o, 3'b001);
        check_eq("fp_rdata0", if_fp.port_rdata_o, 32'h11);
        check_eq("fp_busy", busy_fp, 1);
        tick();
        if_fp.data_rdata_i = 32'h22;
        #1;
        check_eq("fp_rsp2", if_fp.port_rvalid_o, 3'b100);
        tick();
        if_fp.data_rvalid_i = 1'b0;
        #1;
        check_eq("fp_idle_busy", busy_fp, 0);
        check_eq("fp_idle_rvalid", if_fp.port_rvalid_o, 0);

        // Outstanding limit of 2
        tick();
        if_fp.port_req_i = 3'b010;
        if_fp.data_gnt_i = 1'b1;
        #1;
        check_eq("max_gnt1", if_fp.port_gnt_o, 3'b010);
        tick();
        #1;
        check_eq("max_gnt2", if_fp.port_gnt_o, 3'b010);
        tick();
        if_fp.data_rvalid_i = 1'b1;
        #1;
        check_eq("max_full_req", if_fp.data_req_o, 0);
        check_eq("max_full_gnt", if_fp.port_gnt_o, 0);
        check_eq("max_full_busy", busy_fp, 1);
        check_eq("max_full_rsp", if_fp.port_rvalid_o, 3'b010);
        tick();
        if_fp.data_rvalid_i = 1'b0;
        #1;
        check_eq("max_reopen_req", if_fp.data_req_o, 1);
        check_eq("max_reopen_gnt", if_fp.port_gnt_o, 3'b010);
        tick();
        if_fp.port_req_i    = 3'b000;
        if_fp.data_gnt_i    = 1'b0;
        if_fp.data_rvalid_i = 1'b1;
        #1;
        check_eq("max_drain_rsp", if_fp.port_rvalid_o, 3'b010);
        tick();
        tick();
        if_fp.data_rvalid_i = 1'b0;
        #1;
        check_eq("max_drain_busy", busy_fp, 0);

        // Lock held by port 1 keeps port 0 out
        tick();
        if_fp.port_req_i  = 3'b010;
        if_fp.port_lock_i = 3'b010;
        if_fp.data_gnt_i  = 1'b1;
        #1;
        check_eq("lock_take", if_fp.port_gnt_o, 3'b010);
        tick();
        if_fp.port_req_i    = 3'b011;
        if_fp.data_rvalid_i = 1'b1;
        #1;
        check_eq("lock_hold", if_fp.port_gnt_o, 3'b010);
        tick();
        if_fp.port_req_i = 3'b001;
        #1;
        check_eq("lock_block_gnt", if_fp.port_gnt_o, 0);
        check_eq("lock_block_req", if_fp.data_req_o, 0);
        tick();
        if_fp.port_lock_i   = 3'b000;
        if_fp.data_rvalid_i = 1'b0;
        #1;
        check_eq("lock_release", if_fp.port_gnt_o, 3'b001);
        tick();
        if_fp.port_req_i    = 3'b000;
        if_fp.data_gnt_i    = 1'b0;
        if_fp.data_rvalid_i = 1'b1;
        #1;
        check_eq("lock_rsp", if_fp.port_rvalid_o, 3'b001);

        // Write fields mux and error routing on port 1
        tick();
        if_fp.data_rvalid_i = 1'b0;
        if_fp.port_req_i    = 3'b010;
        if_fp.data_gnt_i    = 1'b1;
        if_fp.port_we_i     = 3'b010;
        if_fp.port_be_i     = {4'h0, 4'hC, 4'h3};
        if_fp.port_wdata_i  = {32'h0, 32'hCAFE0001, 32'h5};
        #1;
        check_eq("mux_gnt", if_fp.port_gnt_o, 3'b010);
        check_eq("mux_we", if_fp.data_we_o, 1);
        check_eq("mux_be", if_fp.data_be_o, 4'hC);
        check_eq("mux_wdata", if_fp.data_wdata_o, 32'hCAFE0001);
        check_eq("mux_addr", if_fp.data_addr_o, 32'h200);
        tick();
        if_fp.port_req_i    = 3'b000;
        if_fp.data_gnt_i    = 1'b0;
        if_fp.port_we_i     = 3'b000;
        if_fp.data_rvalid_i = 1'b1;
        if_fp.data_err_i    = 1'b1;
        if_fp.data_rdata_i  = 32'hDEADBEEF;
        #1;
        check_eq("err_rvalid", if_fp.port_rvalid_o, 3'b010);
        check_eq("err_err", if_fp.port_err_o, 3'b010);
        check_eq("err_rdata", if_fp.port_rdata_o, 32'hDEADBEEF);
        check_eq("idle_addr_p0", if_fp.data_addr_o, 32'h100);
        check_eq("idle_be_p0", if_fp.data_be_o, 4'h3);

        // Reset with two outstanding
        tick();
        if_fp.data_rvalid_i = 1'b0;
        if_fp.data_err_i    = 1'b0;
        if_fp.port_req_i    = 3'b011;
        if_fp.data_gnt_i    = 1'b1;
        #1;
        check_eq("rst2_gnt0", if_fp.port_gnt_o, 3'b001);
        tick();
        if_fp.port_req_i = 3'b010;
        #1;
        check_eq("rst2_gnt1", if_fp.port_gnt_o, 3'b010);
        check_eq("rst2_busy", busy_fp, 1);
        tick();
        rst_i            = 1'b1;
        if_fp.port_req_i = 3'b000;
        if_fp.data_gnt_i = 1'b0;
        #1;
        check_eq("rst2_req", if_fp.data_req_o, 0);
        tick();
        rst_i               = 1'b0;
        if_fp.data_rvalid_i = 1'b1;
        #1;
        check_eq("unexp_rvalid", if_fp.port_rvalid_o, 0);
        check_eq("unexp_pulse", unexp_fp, 1);
        check_eq("unexp_busy", busy_fp, 0);
        tick();
        if_fp.data_rvalid_i = 1'b0;
        #1;
        check_eq("unexp_end", unexp_fp, 0);

        // Round-robin: all ports request, memory answers one cycle later
        tick();
        if_rr.port_req_i = 3'b111;
        if_rr.data_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if_rr.data_rvalid_i = (k > 0);
            #1;
            check_eq($sformatf("rr_gnt%0d", k), if_rr.port_gnt_o, 64'(1) << (k % 3));
            check_eq($sformatf("rr_rsp%0d", k), if_rr.port_rvalid_o,
                     (k == 0) ? 64'd0 : (64'(1) << ((k - 1) % 3)));
            tick();
        end
        if_rr.data_gnt_i = 1'b0;
        #1;
        check_eq("rr_nognt_req", if_rr.data_req_o, 1);
        check_eq("rr_nognt_gnt", if_rr.port_gnt_o, 0);
        check_eq("rr_nognt_rsp", if_rr.port_rvalid_o, 3'b100);
        tick();
        if_rr.data_gnt_i    = 1'b1;
        if_rr.data_rvalid_i = 1'b0;
        #1;
        check_eq("rr_hold_ptr", if_rr.port_gnt_o, 3'b001);
        tick();
        if_rr.port_req_i    = 3'b101;
        if_rr.data_rvalid_i = 1'b1;
        #1;
        check_eq("rr_skip", if_rr.port_gnt_o, 3'b100);
        check_eq("rr_skip_rsp", if_rr.port_rvalid_o, 3'b001);
        tick();
        if_rr.port_req_i = 3'b000;
        if_rr.data_gnt_i = 1'b0;
        #1;
        check_eq("rr_last_rsp", if_rr.port_rvalid_o, 3'b100);
        tick();
        if_rr.data_rvalid_i = 1'b0;
        #1;
        check_eq("rr_busy", busy_rr, 0);
        check_eq("rr_unexp", unexp_rr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vcve2_dmem_arbiter_n.md
Name: vcve2_dmem_arbiter_n

Overview:
- N-port data-memory arbiter; successor to the two-port VRF/LSU mux.
- Arbitrates NumPorts requesters (LSU, VRF and future vector lanes) onto one OBI-style data port.
- Tracks up to MaxOutstanding in-flight transactions in an ID FIFO, so rvalid/rdata/err route back to the issuing port.
- Supports fixed-priority or round-robin selection, plus per-port lock for atomic vector bursts.

Parameters:
- NumPorts, 2, number of requesters (2..8); port 0 has highest fixed priority.
- MaxOutstanding, 2, max accepted-but-unanswered transactions (1..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte enable width BeW = DataWidth/8.
- RoundRobin, 1'b0, 0 = fixed priority, 1 = round-robin.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- port_req_i  in  NumPorts  per-port request.
- port_gnt_o  out  NumPorts  per-port grant, one-hot or zero.
- port_rvalid_o  out  NumPorts  per-port response valid, one-hot or zero.
- port_err_o  out  NumPorts  per-port response error, qualified by port_rvalid_o.
- port_lock_i  in  NumPorts  hold ownership after grant.
- port_we_i  in  NumPorts  write enable.
- port_be_i  in  NumPorts*BeW  byte enables.
- port_addr_i  in  NumPorts*AddrWidth  addresses.
- port_wdata_i  in  NumPorts*DataWidth  write data.
- port_rdata_o  out  DataWidth  read data, broadcast to all ports.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  memory response valid.
- data_we_o  out  1  write enable.
- data_be_o  out  BeW  byte enables.
- data_addr_o  out  AddrWidth  address.
- data_wdata_o  out  DataWidth  write data.
- data_rdata_i  in  DataWidth  read data.
- data_err_i  in  1  response error.
- busy_o  out  1  outstanding count != 0.
- unexp_rsp_o  out  1  one-cycle pulse: data_rvalid_i seen with empty FIFO.

Behaviour:
- Reset:
  - While rst_i=1: data_req_o=0, port_gnt_o=0, port_rvalid_o=0, port_err_o=0, unexp_rsp_o=0.
  - rr pointer=0, count=0, FIFO empty, lock cleared, busy_o=0.
  - Reset mid-transaction drops all in-flight IDs. Later data_rvalid_i pulses unexp_rsp_o and is not forwarded.
- Eligibility:
  - Port k is eligible iff port_req_i[k]=1.
  - If lock is held by owner j, only j is eligible.
  - If count==MaxOutstanding, no port is eligible. A pop in the same cycle does not lift this block.
- Winner selection (combinational, same cycle):
  - Fixed priority: lowest eligible index.
  - Round-robin: first eligible index at or after rr pointer, wrapping NumPorts-1 -> 0.
- Memory-side mux:
  - data_req_o=1 iff a winner exists.
  - data_we/be/addr/wdata_o take the winner's fields. With no winner they take port 0's fields.
- Grant:
  - port_gnt_o[w] = data_gnt_i && winner==w; zero-latency pass-through.
  - On a grant: push w into the FIFO.
  - In round-robin mode, rr pointer <= (w+1) mod NumPorts. The pointer does not advance without a grant.
- Lock:
  - On a grant to w with port_lock_i[w]=1, lock owner <= w (registered).
  - Lock clears on any cycle with port_lock_i[owner]=0; that same cycle, all ports are eligible again.
  - While locked, port_req_i of other ports is held off with no grant.
- Response:
  - On data_rvalid_i with FIFO non-empty, head h gets port_rvalid_o[h]=1 and port_err_o[h]=data_err_i, then pop.
  - port_rdata_o = data_rdata_i always.
  - Responses are in order; the memory never reorders.
- Count:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - Count never exceeds MaxOutstanding and never underflows.
- Request stability: a requester holds req and fields until its gnt. The arbiter may switch winner before data_gnt_i only if the higher-priority port rises; a bench checks no grant is lost.

Test Plan:
- Fixed priority, NumPorts=3, ports 0 and 2 request, data_gnt_i=1 -> port_gnt_o=3'b001. Next cycle, port 0 drops -> 3'b100. Responses return in the order port 0, port 2.
- Round-robin, NumPorts=3, all request continuously, gnt=1 every cycle -> grants 0,1,2,0,1,2; rr pointer wraps 2 -> 0.
- MaxOutstanding=2, two grants with no rvalid -> data_req_o=0 and busy_o=1 in cycle 3. An rvalid pops the head; data_req_o returns to 1 the cycle after.
- Lock: port 1 granted with lock_i[1]=1 while port 0 requests -> port 0 receives no grant until lock_i[1]=0. That cycle, port 0 is granted under fixed priority.
- Error routing: port 1 transaction outstanding, data_rvalid_i=1 with data_err_i=1 and data_rdata_i=32'hDEADBEEF -> port_rvalid_o=2'b10, port_err_o=2'b10, port_rdata_o=32'hDEADBEEF.
- Reset with 2 outstanding, then data_rvalid_i=1 -> port_rvalid_o=0, unexp_rsp_o pulses 1 cycle, busy_o=0.
